// File: rtl/mac_rx_frame_parser.sv
`default_nettype none
// ============================================================================
//  Module   : mac_rx_frame_parser
//  Purpose  : GMII-style byte receive front end. Strips preamble/SFD, tags
//             each forwarded byte with the frame state, checks FCS (CRC-32
//             residue) and frame length, and pulses oerror on a rejected frame.
//  Revision : 1.0 - initial release
//
//  Ports
//    iclk        in   1   clock
//    i_rst       in   1   reset, asynchronous, active-low
//    i_dv        in   1   rx data valid from PHY
//    i_er        in   1   rx error from PHY
//    i_rxd       in   8   rx byte from PHY
//    odv         out  1   byte valid to packet memory (SFD and frame bytes)
//    orx_d       out  8   byte to packet memory (i_rxd delayed one cycle)
//    oFSM_state  out  3   state entered for the byte on orx_d
//                         IDLE=0 PREAMBLE=1 DELIMETER=2 DATA=3 DROP=4
//    oerror      out  1   one-cycle frame-reject pulse
//
//  Optional feature macro: MAC_RX_STATS_EN
//    When defined, adds ogood_cnt[15:0] / obad_cnt[15:0] saturating
//    counters of cleanly ended frames and of oerror pulses.
// ============================================================================
module mac_rx_frame_parser #(
  parameter int unsigned pDATA_WIDTH        = 8,
  parameter int unsigned pMIN_PACKET_LENGHT = 64,
  parameter int unsigned pMAX_PACKET_LENGHT = 1536,
  parameter int unsigned pMIN_PREAMBLE      = 1
) (
  input  logic                   iclk,
  input  logic                   i_rst,
  input  logic                   i_dv,
  input  logic                   i_er,
  input  logic [pDATA_WIDTH-1:0] i_rxd,
  output logic                   odv,
  output logic [pDATA_WIDTH-1:0] orx_d,
  output logic [2:0]             oFSM_state,
  output logic                   oerror
`ifdef MAC_RX_STATS_EN
  ,
  output logic [15:0]            ogood_cnt,
  output logic [15:0]            obad_cnt
`endif
);

  localparam logic [2:0]  lpIDLE      = 3'd0;
  localparam logic [2:0]  lpPREAMBLE  = 3'd1;
  localparam logic [2:0]  lpDELIMETER = 3'd2;
  localparam logic [2:0]  lpDATA      = 3'd3;
  localparam logic [2:0]  lpDROP      = 3'd4;

  localparam logic [31:0] lpCRC_INIT    = 32'hFFFF_FFFF;
  localparam logic [31:0] lpCRC_POLY    = 32'hEDB8_8320;
  localparam logic [31:0] lpCRC_RESIDUE = 32'hDEBB_20E3;

  localparam logic [10:0] lpMIN_LEN = 11'(pMIN_PACKET_LENGHT);
  localparam logic [10:0] lpMAX_LEN = 11'(pMAX_PACKET_LENGHT);
  localparam logic [2:0]  lpMIN_PRE = 3'(pMIN_PREAMBLE);

  // Reflected CRC-32, one byte, LSB first.
  function automatic logic [31:0] f_crc_byte(input logic [31:0] crc, input logic [7:0] d);
    logic [31:0] c;
    c = crc;
    for (int i = 0; i < 8; i++) begin
      if (c[0] ^ d[i]) c = (c >> 1) ^ lpCRC_POLY;
      else             c = c >> 1;
    end
    return c;
  endfunction

  logic [2:0]             r_state;
  logic [2:0]             w_next;
  logic [2:0]             r_pre_cnt;
  logic [10:0]            r_len;
  logic [31:0]            r_crc;
  logic                   r_odv;
  logic [pDATA_WIDTH-1:0] r_rxd;
  logic                   r_err;

  logic                   w_odv_nxt;
  logic                   w_err_nxt;
  logic                   w_is_pre;
  logic                   w_is_sfd;
  logic                   w_pre_ok;
  logic                   w_len_full;
  logic                   w_frame_bad;

  assign w_is_pre    = (i_rxd == 8'h55);
  assign w_is_sfd    = (i_rxd == 8'hD5);
  assign w_pre_ok    = (r_pre_cnt >= lpMIN_PRE);
  // Frame already holds the maximum; one more byte would overflow.
  assign w_len_full  = (r_len >= lpMAX_LEN);
  assign w_frame_bad = (r_crc != lpCRC_RESIDUE) || (r_len < lpMIN_LEN);

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge iclk or negedge i_rst) begin
    if (!i_rst) r_state <= lpIDLE;
    else        r_state <= w_next;
  end

  // --------------------------------------------------------------------------
  // Next-state logic. i_er only matters on a valid byte; a falling i_dv
  // always wins so the end-of-frame check is never skipped.
  // --------------------------------------------------------------------------
  always_comb begin
    w_next = r_state;
    case (r_state)
      lpIDLE: begin
        if (i_dv) w_next = (i_er || !w_is_pre) ? lpDROP : lpPREAMBLE;
      end
      lpPREAMBLE: begin
        if (!i_dv)                     w_next = lpIDLE;
        else if (i_er)                 w_next = lpDROP;
        else if (w_is_pre)             w_next = lpPREAMBLE;
        else if (w_is_sfd && w_pre_ok) w_next = lpDELIMETER;
        else                           w_next = lpDROP;
      end
      lpDELIMETER: begin
        if (!i_dv)     w_next = lpIDLE;
        else if (i_er) w_next = lpDROP;
        else           w_next = lpDATA;
      end
      lpDATA: begin
        if (!i_dv)                  w_next = lpIDLE;
        else if (i_er || w_len_full) w_next = lpDROP;
        else                        w_next = lpDATA;
      end
      lpDROP: begin
        if (!i_dv) w_next = lpIDLE;
      end
      default: w_next = lpIDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // Output logic (registered below). Only the SFD and frame bytes are valid;
  // errors are raised only when leaving DATA.
  // --------------------------------------------------------------------------
  always_comb begin
    w_odv_nxt = (w_next == lpDELIMETER) || (w_next == lpDATA);
    w_err_nxt = 1'b0;
    if (r_state == lpDATA) begin
      if (!i_dv) w_err_nxt = w_frame_bad;
      else       w_err_nxt = i_er || w_len_full;
    end
  end

  always_ff @(posedge iclk or negedge i_rst) begin
    if (!i_rst) begin
      r_odv <= 1'b0;
      r_rxd <= '0;
      r_err <= 1'b0;
    end else begin
      r_odv <= w_odv_nxt;
      r_rxd <= i_rxd;
      r_err <= w_err_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // Preamble counter, length counter and running CRC
  // --------------------------------------------------------------------------
  always_ff @(posedge iclk or negedge i_rst) begin
    if (!i_rst) begin
      r_pre_cnt <= 3'd0;
      r_len     <= 11'd0;
      r_crc     <= lpCRC_INIT;
    end else begin
      // The 0x55 that moves IDLE->PREAMBLE is the first preamble byte.
      if (w_next == lpPREAMBLE) begin
        if (r_state == lpPREAMBLE)
          r_pre_cnt <= (r_pre_cnt == 3'd7) ? 3'd7 : r_pre_cnt + 3'd1;
        else
          r_pre_cnt <= 3'd1;
      end else begin
        r_pre_cnt <= 3'd0;
      end

      if (w_next == lpDATA) begin
        if (r_state == lpDELIMETER) begin
          r_len <= 11'd1;
          r_crc <= f_crc_byte(lpCRC_INIT, i_rxd[7:0]);
        end else begin
          r_len <= r_len + 11'd1;
          r_crc <= f_crc_byte(r_crc, i_rxd[7:0]);
        end
      end else begin
        r_len <= 11'd0;
        r_crc <= lpCRC_INIT;
      end
    end
  end

  assign odv        = r_odv;
  assign orx_d      = r_rxd;
  assign oFSM_state = r_state;
  assign oerror     = r_err;

`ifdef MAC_RX_STATS_EN
  logic [15:0] r_good_cnt;
  logic [15:0] r_bad_cnt;
  logic        w_good_end;

  assign w_good_end = (r_state == lpDATA) && !i_dv && !w_frame_bad;

  always_ff @(posedge iclk or negedge i_rst) begin
    if (!i_rst) begin
      r_good_cnt <= 16'd0;
      r_bad_cnt  <= 16'd0;
    end else begin
      if (w_good_end && (r_good_cnt != 16'hFFFF)) r_good_cnt <= r_good_cnt + 16'd1;
      if (w_err_nxt  && (r_bad_cnt  != 16'hFFFF)) r_bad_cnt  <= r_bad_cnt  + 16'd1;
    end
  end

  assign ogood_cnt = r_good_cnt;
  assign obad_cnt  = r_bad_cnt;
`endif

endmodule
`default_nettype wire

// File: tb/tb_mac_rx_frame_parser.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mac_rx_frame_parser
//  Purpose  : Self-checking bench for mac_rx_frame_parser. Each receive burst
//             is described as a byte/error list; a burst-level model derives
//             the expected per-cycle outputs and a compare process checks them.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_mac_rx_frame_parser;

  localparam int MIN_LEN = 64;
  localparam int MAX_LEN = 1536;
  localparam int MIN_PRE = 1;

  localparam logic [2:0] S_IDLE = 3'd0, S_PRE = 3'd1, S_DEL = 3'd2, S_DATA = 3'd3, S_DROP = 3'd4;

  logic       iclk  = 1'b0;
  logic       i_rst = 1'b0;
  logic       i_dv  = 1'b0;
  logic       i_er  = 1'b0;
  logic [7:0] i_rxd = 8'h00;
  logic       odv;
  logic [7:0] orx_d;
  logic [2:0] oFSM_state;
  logic       oerror;
`ifdef MAC_RX_STATS_EN
  logic [15:0] ogood_cnt;
  logic [15:0] obad_cnt;
`endif

  mac_rx_frame_parser dut (
    .iclk       (iclk),
    .i_rst      (i_rst),
    .i_dv       (i_dv),
    .i_er       (i_er),
    .i_rxd      (i_rxd),
    .odv        (odv),
    .orx_d      (orx_d),
    .oFSM_state (oFSM_state),
    .oerror     (oerror)
`ifdef MAC_RX_STATS_EN
    ,
    .ogood_cnt  (ogood_cnt),
    .obad_cnt   (obad_cnt)
`endif
  );

  always #5 iclk = ~iclk;

  typedef struct {
    logic [2:0] st;
    logic       dv;
    logic [7:0] d;
    logic       err;
  } exp_t;

  exp_t       exp_q[$];
  exp_t       m_exp[$];
  logic [7:0] m_b[$];
  bit         m_e[$];
  exp_t       cmp_t;

  int n_vec    = 0;
  int n_err    = 0;
  int odv_seen = 0;
  int m_good   = 0;
  int m_bad    = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  function automatic exp_t mk(input logic [2:0] st, input logic dv, input logic [7:0] d, input logic err);
    exp_t t;
    t.st = st; t.dv = dv; t.d = d; t.err = err;
    return t;
  endfunction

  // Standard Ethernet CRC-32 over m_b[first..last] (final inversion applied).
  function automatic logic [31:0] crc32_mb(input int first, input int last);
    logic [31:0] c;
    c = 32'hFFFF_FFFF;
    for (int i = first; i <= last; i++) begin
      c = c ^ {24'h0, m_b[i]};
      for (int j = 0; j < 8; j++) c = c[0] ? ((c >> 1) ^ 32'hEDB8_8320) : (c >> 1);
    end
    return ~c;
  endfunction

  // npre x 0x55, SFD, npay random bytes, FCS little-endian.
  task automatic new_frame(input int npre, input int npay);
    logic [31:0] c;
    m_b.delete(); m_e.delete();
    for (int i = 0; i < npre; i++) m_b.push_back(8'h55);
    m_b.push_back(8'hD5);
    for (int i = 0; i < npay; i++) m_b.push_back(8'($urandom));
    c = crc32_mb(npre + 1, m_b.size() - 1);
    m_b.push_back(c[7:0]);  m_b.push_back(c[15:8]);
    m_b.push_back(c[23:16]); m_b.push_back(c[31:24]);
    for (int i = 0; i < m_b.size(); i++) m_e.push_back(1'b0);
  endtask

  // Burst-level reference: parse the whole burst, then list the expected
  // output for each input cycle plus the terminating i_dv=0 cycle.
  task automatic build_expect();
    int   L, p, ds, n;
    bit   dropped, in_data;
    logic end_err;
    L = m_b.size(); p = 0; dropped = 0; in_data = 0; end_err = 0;
    m_exp.delete();
    while (p < L && m_b[p] == 8'h55 && !m_e[p]) p++;
    if (p == 0) begin
      for (int k = 0; k < L; k++) m_exp.push_back(mk(S_DROP, 0, 8'h00, 0));
    end else begin
      for (int k = 0; k < p; k++) m_exp.push_back(mk(S_PRE, 0, 8'h00, 0));
      if (p < L) begin
        if (m_b[p] == 8'hD5 && !m_e[p] && ((p > 7) ? 7 : p) >= MIN_PRE) begin
          m_exp.push_back(mk(S_DEL, 1, 8'hD5, 0));
          for (int k = p + 1; k < L; k++) begin
            if (dropped) m_exp.push_back(mk(S_DROP, 0, 8'h00, 0));
            else if (m_e[k] || (k - p) > MAX_LEN) begin
              m_exp.push_back(mk(S_DROP, 0, 8'h00, 1));
              dropped = 1;
              m_bad++;
            end else m_exp.push_back(mk(S_DATA, 1, m_b[k], 0));
          end
          in_data = !dropped && (L > p + 1);
        end else begin
          for (int k = p; k < L; k++) m_exp.push_back(mk(S_DROP, 0, 8'h00, 0));
        end
      end
    end
    if (in_data) begin
      ds = p + 1;
      n  = L - ds;
      if (n < MIN_LEN || n < 4) end_err = 1;
      else if (crc32_mb(ds, L - 5) != {m_b[L-1], m_b[L-2], m_b[L-3], m_b[L-4]}) end_err = 1;
      if (end_err) m_bad++;
      else         m_good++;
    end
    m_exp.push_back(mk(S_IDLE, 0, 8'h00, end_err));
  endtask

  task automatic run_burst(input int gap);
    int L;
    build_expect();
    L = m_b.size();
    for (int k = 0; k <= L; k++) begin
      @(negedge iclk);
      i_dv  = (k < L);
      i_er  = (k < L) ? m_e[k] : 1'b0;
      i_rxd = (k < L) ? m_b[k] : 8'($urandom);
      exp_q.push_back(m_exp[k]);
    end
    for (int g = 0; g < gap; g++) begin
      @(negedge iclk);
      i_dv = 1'b0; i_er = 1'b0; i_rxd = 8'($urandom);
      exp_q.push_back(mk(S_IDLE, 0, 8'h00, 0));
    end
  endtask

  task automatic drain();
    @(negedge iclk);
    i_dv = 1'b0; i_er = 1'b0;
    repeat (3) @(negedge iclk);
  endtask

  task automatic check_stats();
`ifdef MAC_RX_STATS_EN
    check("ogood_cnt", {16'h0, ogood_cnt}, m_good);
    check("obad_cnt",  {16'h0, obad_cnt},  m_bad);
`endif
  endtask

  // Single compare process: every cycle that has a queued expectation.
  always begin
    @(posedge iclk);
    #2;
    if (exp_q.size() > 0) begin
      cmp_t = exp_q.pop_front();
      check("oFSM_state", {29'h0, oFSM_state}, {29'h0, cmp_t.st});
      check("odv",        {31'h0, odv},        {31'h0, cmp_t.dv});
      check("oerror",     {31'h0, oerror},     {31'h0, cmp_t.err});
      if (cmp_t.dv) check("orx_d", {24'h0, orx_d}, {24'h0, cmp_t.d});
      if (odv === 1'b1) odv_seen++;
    end
  end

  initial begin
    int L, typ, sub, n, idx;

    // ---------------- reset state ----------------
    repeat (3) @(negedge iclk);
    check("rst_state", {29'h0, oFSM_state}, 32'd0);
    check("rst_odv",   {31'h0, odv},        32'd0);
    check("rst_err",   {31'h0, oerror},     32'd0);
    check("rst_rxd",   {24'h0, orx_d},      32'd0);
    check_stats();
    i_rst = 1'b1;
    repeat (2) @(negedge iclk);

    // ---------------- pin the CRC model ----------------
    m_b.delete();
    for (int i = 0; i < 9; i++) m_b.push_back(8'h31 + 8'(i));
    check("crc_123456789", crc32_mb(0, 8), 32'hCBF4_3926);

    // ---------------- 7x55, D5, 60 payload + FCS ----------------
    odv_seen = 0;
    new_frame(7, 60);
    run_burst(2);
    drain();
    check("good_odv_cycles", odv_seen, 32'd65);
    check("good_model_del",  {29'h0, m_exp[7].st}, 32'd2);
    check("good_model_data", {29'h0, m_exp[8].st}, 32'd3);
    check("good_model_err",  {31'h0, m_exp[72].err}, 32'd0);

    // ---------------- same frame, last FCS byte flipped ----------------
    new_frame(7, 60);
    m_b[m_b.size()-1] = m_b[m_b.size()-1] ^ 8'h01;
    run_burst(1);
    check("badfcs_model_err", {31'h0, m_exp[72].err}, 32'd1);
    check("badfcs_model_st",  {29'h0, m_exp[72].st},  32'd0);

    // ---------------- runt: 55, D5, 40 bytes incl. valid FCS ----------------
    new_frame(1, 36);
    run_burst(1);
    check("runt_model_err", {31'h0, m_exp[42].err}, 32'd1);
    drain();
    check_stats();

    // ---------------- oversize: 1600 bytes after SFD ----------------
    m_b.delete(); m_e.delete();
    m_b.push_back(8'h55); m_b.push_back(8'hD5);
    for (int i = 0; i < 1600; i++) m_b.push_back(8'($urandom));
    for (int i = 0; i < m_b.size(); i++) m_e.push_back(1'b0);
    run_burst(1);
    check("over_model_last_ok", {29'h0, m_exp[1537].st}, 32'd3);
    check("over_model_err",     {31'h0, m_exp[1538].err}, 32'd1);
    check("over_model_drop",    {29'h0, m_exp[1538].st}, 32'd4);
    check("over_model_end",     {29'h0, m_exp[1602].st}, 32'd0);

    // ---------------- exactly maximum length accepted ----------------
    new_frame(2, MAX_LEN - 4);
    run_burst(1);
    check("max_model_err", {31'h0, m_exp[m_exp.size()-1].err}, 32'd0);

    // ---------------- i_er at DATA byte 20, then a good frame ----------------
    new_frame(7, 60);
    m_e[27] = 1'b1;
    run_burst(0);
    check("er_model_err", {31'h0, m_exp[27].err}, 32'd1);
    check("er_model_st",  {29'h0, m_exp[27].st},  32'd4);
    new_frame(7, 60);
    run_burst(1);
    drain();
    check_stats();

    // ---------------- reset at DATA byte 30, released with i_dv high ----------------
    new_frame(7, 60);
    for (int k = 0; k < 37; k++) begin
      @(negedge iclk);
      i_dv = 1'b1; i_er = 1'b0; i_rxd = m_b[k];
    end
    @(negedge iclk);
    i_rst = 1'b0; i_rxd = 8'hA7;
    #1;
    check("midrst_odv",   {31'h0, odv},        32'd0);
    check("midrst_state", {29'h0, oFSM_state}, 32'd0);
    check("midrst_err",   {31'h0, oerror},     32'd0);
    m_good = 0; m_bad = 0;
    repeat (2) @(negedge iclk);
    i_rst = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(posedge iclk); #2;
      check("postrst_state", {29'h0, oFSM_state}, 32'd4);
      check("postrst_odv",   {31'h0, odv},        32'd0);
      check("postrst_err",   {31'h0, oerror},     32'd0);
    end
    @(negedge iclk);
    i_dv = 1'b0;
    @(posedge iclk); #2;
    check("postrst_idle", {29'h0, oFSM_state}, 32'd0);
    new_frame(3, 70);
    run_burst(1);
    drain();
    check_stats();

    // ---------------- randomized bursts ----------------
    for (int f = 0; f < 120; f++) begin
      typ = $urandom_range(0, 9);
      case (typ)
        0, 1, 2, 3: new_frame($urandom_range(1, 7), $urandom_range(60, 120));
        4: begin
          new_frame($urandom_range(1, 7), $urandom_range(60, 100));
          idx = $urandom_range(0, m_b.size() - 1 - 1);
          while (m_b[idx] == 8'h55 || m_b[idx] == 8'hD5) idx++;
          idx = m_b.size() - 1 - $urandom_range(0, 60);
          m_b[idx] = m_b[idx] ^ (8'h01 << $urandom_range(0, 7));
        end
        5: new_frame($urandom_range(1, 7), $urandom_range(0, 59));
        6: begin
          new_frame($urandom_range(1, 7), $urandom_range(60, 100));
          n = m_b.size();
          m_e[n - 1 - $urandom_range(0, 60)] = 1'b1;
        end
        7: begin
          m_b.delete(); m_e.delete();
          L = $urandom_range(1, 20);
          for (int i = 0; i < L; i++) begin
            m_b.push_back(($urandom_range(0, 3) == 0) ? 8'h55 : 8'($urandom));
            m_e.push_back($urandom_range(0, 15) == 0);
          end
        end
        8: begin
          m_b.delete(); m_e.delete();
          sub = $urandom_range(0, 3);
          n = $urandom_range(1, 9);
          for (int i = 0; i < n; i++) m_b.push_back(8'h55);
          if (sub == 1) m_b.push_back(8'hD5);
          if (sub == 2) begin
            m_b.push_back(8'hA3);
            for (int i = 0; i < 5; i++) m_b.push_back(8'($urandom));
          end
          if (sub == 3) for (int i = 0; i < 4; i++) m_b.push_back(8'hD5);
          for (int i = 0; i < m_b.size(); i++) m_e.push_back(1'b0);
          if (sub == 3) m_e[$urandom_range(0, n - 1)] = 1'b1;
        end
        default: begin
          m_b.delete(); m_e.delete();
          m_b.push_back(8'h55); m_b.push_back(8'hD5);
          L = $urandom_range(1537, 1560);
          for (int i = 0; i < L; i++) m_b.push_back(8'($urandom));
          for (int i = 0; i < m_b.size(); i++) m_e.push_back(1'b0);
        end
      endcase
      run_burst($urandom_range(0, 2));
    end
    drain();
    check_stats();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
